// File: rtl/order_manager.sv
// Order entry and pre-trade risk gate: two-edge pipeline, per-symbol position/PnL tables.
// Optional PnL tracking is built only when ORDER_MANAGER_PNL_EN is defined.
module order_manager #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned MAX_ORDERS        = 1024,
   parameter int unsigned MAX_SYMBOLS       = 256,
   parameter int unsigned MAX_POSITION_SIZE = 1000000,
   parameter logic [31:0] MAX_ORDER_VOLUME  = 32'hF0000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  order_valid,
   input  logic [DATA_WIDTH-1:0] order_symbol,
   input  logic [DATA_WIDTH-1:0] order_price,
   input  logic [DATA_WIDTH-1:0] order_volume,
   input  logic [7:0]            order_type,
   input  logic [DATA_WIDTH-1:0] order_id,
   output logic                  order_ready,
   output logic                  execution_valid,
   output logic [DATA_WIDTH-1:0] execution_id,
   output logic [DATA_WIDTH-1:0] execution_price,
   output logic [DATA_WIDTH-1:0] execution_volume,
   output logic [7:0]            execution_status,
   output logic                  risk_violation,
   output logic [7:0]            risk_code,
   output logic                  position_update,
   output logic [DATA_WIDTH-1:0] position_symbol,
   output logic [DATA_WIDTH-1:0] position_size,
   output logic [DATA_WIDTH-1:0] position_pnl
);

   localparam logic [7:0] TYPE_BUY    = 8'h01;
   localparam logic [7:0] TYPE_SELL   = 8'h02;
   localparam logic [7:0] TYPE_CANCEL = 8'h03;

   localparam logic [7:0] ST_FILLED        = 8'h01;
   localparam logic [7:0] ST_REJECTED      = 8'h02;
   localparam logic [7:0] ST_CANCELLED     = 8'h03;
   localparam logic [7:0] ST_CANCEL_REJECT = 8'h04;

   localparam logic [7:0] RC_NONE     = 8'h00;
   localparam logic [7:0] RC_VOLUME   = 8'h01;
   localparam logic [7:0] RC_ZERO     = 8'h02;
   localparam logic [7:0] RC_POSITION = 8'h03;
   localparam logic [7:0] RC_TYPE     = 8'h04;

   localparam int unsigned IDX_W = $clog2(MAX_SYMBOLS);
   localparam int unsigned SEQ_W = $clog2(MAX_ORDERS);
   localparam logic signed [32:0] POS_LIM = 33'(MAX_POSITION_SIZE);

   logic        ready_q;
   logic        accept;
   logic        s1_valid_q;
   logic [31:0] s1_symbol_q, s1_price_q, s1_volume_q, s1_id_q;
   logic [7:0]  s1_type_q;
   logic        cx_valid_q;
   logic [31:0] cx_id_q;
   logic [SEQ_W-1:0] seq_q;

   logic              [7:0]       sym_xor;
   logic              [IDX_W-1:0] s1_idx;
   logic              [7:0]       shares;
   logic                          is_buy, is_trade, cancel_hit, pos_over;
   logic signed       [32:0]      new_pos;
   logic              [7:0]       code;
   logic signed       [31:0]      pos_tbl [MAX_SYMBOLS];

   logic        exec_valid_q, pos_update_q, risk_q;
   logic [31:0] exec_id_q, exec_price_q, exec_volume_q;
   logic [7:0]  exec_status_q, risk_code_q;
   logic [31:0] pos_symbol_q, pos_size_q;

   assign accept = order_valid && ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_symbol_q <= '0;
         s1_price_q  <= '0;
         s1_volume_q <= '0;
         s1_type_q   <= '0;
         s1_id_q     <= '0;
         cx_valid_q  <= 1'b0;
         cx_id_q     <= '0;
         seq_q       <= '0;
      end else begin
         ready_q    <= 1'b1;
         s1_valid_q <= accept && (order_type != TYPE_CANCEL);
         cx_valid_q <= accept && (order_type == TYPE_CANCEL) && !cancel_hit;
         if (accept) begin
            seq_q <= seq_q + 1'b1;
         end
         if (accept && order_type != TYPE_CANCEL) begin
            s1_symbol_q <= order_symbol;
            s1_price_q  <= order_price;
            s1_volume_q <= order_volume;
            s1_type_q   <= order_type;
            s1_id_q     <= order_id;
         end
         if (accept && order_type == TYPE_CANCEL) begin
            cx_id_q <= order_id;
         end
      end
   end

   // A cancel kills the order sitting in S1 on the very edge that order is evaluated.
   assign cancel_hit = accept && (order_type == TYPE_CANCEL) && s1_valid_q && is_trade
                       && (order_id == s1_id_q);

   always_comb begin
      sym_xor  = s1_symbol_q[31:24] ^ s1_symbol_q[23:16] ^ s1_symbol_q[15:8] ^ s1_symbol_q[7:0];
      s1_idx   = sym_xor[IDX_W-1:0];
      shares   = s1_volume_q[31:24];
      is_buy   = (s1_type_q == TYPE_BUY);
      is_trade = is_buy || (s1_type_q == TYPE_SELL);
      new_pos  = is_buy ? ({pos_tbl[s1_idx][31], pos_tbl[s1_idx]} + {25'd0, shares})
                        : ({pos_tbl[s1_idx][31], pos_tbl[s1_idx]} - {25'd0, shares});
      pos_over = (new_pos > POS_LIM) || (new_pos < -POS_LIM);
      code     = RC_NONE;
      if (!is_trade) begin
         code = RC_TYPE;
      end else if (s1_price_q == '0 || s1_volume_q == '0) begin
         code = RC_ZERO;
      end else if (s1_volume_q > MAX_ORDER_VOLUME) begin
         code = RC_VOLUME;
      end else if (pos_over) begin
         code = RC_POSITION;
      end
   end

   logic do_fill;
   assign do_fill = s1_valid_q && !cancel_hit && (code == RC_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_tbl <= '{default: '0};
      end else if (do_fill) begin
         pos_tbl[s1_idx] <= new_pos[31:0];
      end
   end

`ifdef ORDER_MANAGER_PNL_EN
   logic [31:0] pnl_tbl [MAX_SYMBOLS];
   logic [31:0] notional, new_pnl, pnl_q;

   always_comb begin
      notional = s1_price_q * {24'd0, shares};
      new_pnl  = is_buy ? (pnl_tbl[s1_idx] - notional) : (pnl_tbl[s1_idx] + notional);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pnl_tbl <= '{default: '0};
         pnl_q   <= '0;
      end else if (do_fill) begin
         pnl_tbl[s1_idx] <= new_pnl;
         pnl_q           <= new_pnl;
      end
   end

   assign position_pnl = pnl_q;
`else
   assign position_pnl = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_valid_q  <= 1'b0;
         exec_id_q     <= '0;
         exec_price_q  <= '0;
         exec_volume_q <= '0;
         exec_status_q <= '0;
         risk_q        <= 1'b0;
         risk_code_q   <= '0;
         pos_update_q  <= 1'b0;
         pos_symbol_q  <= '0;
         pos_size_q    <= '0;
      end else begin
         exec_valid_q <= 1'b0;
         pos_update_q <= 1'b0;
         if (s1_valid_q) begin
            exec_valid_q <= 1'b1;
            exec_id_q    <= s1_id_q;
            if (cancel_hit) begin
               exec_status_q <= ST_CANCELLED;
               exec_price_q  <= '0;
               exec_volume_q <= '0;
            end else if (code != RC_NONE) begin
               exec_status_q <= ST_REJECTED;
               exec_price_q  <= '0;
               exec_volume_q <= '0;
               risk_q        <= 1'b1;
               risk_code_q   <= code;
            end else begin
               exec_status_q <= ST_FILLED;
               exec_price_q  <= s1_price_q;
               exec_volume_q <= s1_volume_q;
               risk_q        <= 1'b0;
               risk_code_q   <= RC_NONE;
               pos_update_q  <= 1'b1;
               pos_symbol_q  <= s1_symbol_q;
               pos_size_q    <= new_pos[31:0];
            end
         end else if (cx_valid_q) begin
            exec_valid_q  <= 1'b1;
            exec_id_q     <= cx_id_q;
            exec_status_q <= ST_CANCEL_REJECT;
            exec_price_q  <= '0;
            exec_volume_q <= '0;
         end
      end
   end

   assign order_ready      = ready_q;
   assign execution_valid  = exec_valid_q;
   assign execution_id     = exec_id_q;
   assign execution_price  = exec_price_q;
   assign execution_volume = exec_volume_q;
   assign execution_status = exec_status_q;
   assign risk_violation   = risk_q;
   assign risk_code        = risk_code_q;
   assign position_update  = pos_update_q;
   assign position_symbol  = pos_symbol_q;
   assign position_size    = pos_size_q;

   a_seq_step: assert property (@(posedge clk) disable iff (!rst_n)
      accept |=> (seq_q == SEQ_W'($past(seq_q) + 1'b1)));

endmodule

// File: tb/tb_order_manager.sv
// Scoreboard bench for order_manager: driver pushes expected reports, monitor pops and compares.
module tb_order_manager;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        order_valid = 1'b0;
   logic [31:0] order_symbol = '0, order_price = '0, order_volume = '0, order_id = '0;
   logic [7:0]  order_type = '0;
   logic        order_ready, execution_valid, risk_violation, position_update;
   logic [31:0] execution_id, execution_price, execution_volume;
   logic [7:0]  execution_status, risk_code;
   logic [31:0] position_symbol, position_size, position_pnl;

   order_manager dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .order_valid      (order_valid),
      .order_symbol     (order_symbol),
      .order_price      (order_price),
      .order_volume     (order_volume),
      .order_type       (order_type),
      .order_id         (order_id),
      .order_ready      (order_ready),
      .execution_valid  (execution_valid),
      .execution_id     (execution_id),
      .execution_price  (execution_price),
      .execution_volume (execution_volume),
      .execution_status (execution_status),
      .risk_violation   (risk_violation),
      .risk_code        (risk_code),
      .position_update  (position_update),
      .position_symbol  (position_symbol),
      .position_size    (position_size),
      .position_pnl     (position_pnl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] id, price, volume;
      logic [7:0]  status;
      logic        rv;
      logic [7:0]  rc;
      logic        pu;
      logic [31:0] psym, psize, ppnl;
   } exp_t;

   exp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   localparam logic [31:0] AAPL = 32'h41415054;
   localparam logic [31:0] MSFT = 32'h4D534654;
   localparam logic [31:0] GOOG = 32'h474F4F47;
   localparam logic [31:0] IBMX = 32'h49424D20;

   // Reference model state
   longint      pos_m [256];
   logic [31:0] pnl_m [256];
   logic        rv_m = 1'b0;
   logic [7:0]  rc_m = '0;
   logic        pend_v = 1'b0;
   logic [31:0] pend_sym, pend_price, pend_vol, pend_id;
   logic [7:0]  pend_type;

   function automatic logic [7:0] sym_idx(input logic [31:0] s);
      return s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 256; i++) begin
         pos_m[i] = 0;
         pnl_m[i] = '0;
      end
      rv_m = 1'b0;
      rc_m = '0;
      pend_v = 1'b0;
      exp_q.delete();
   endtask

   task automatic flush_pend();
      exp_t e;
      logic [7:0]  ix, code;
      longint      np;
      logic [31:0] sh, prod;
      if (!pend_v) return;
      pend_v = 1'b0;
      ix = sym_idx(pend_sym);
      sh = {24'd0, pend_vol[31:24]};
      np = (pend_type == 8'h01) ? pos_m[ix] + longint'(sh) : pos_m[ix] - longint'(sh);
      code = 8'h00;
      if (pend_type != 8'h01 && pend_type != 8'h02) code = 8'h04;
      else if (pend_price == 0 || pend_vol == 0) code = 8'h02;
      else if (pend_vol > 32'hF0000000) code = 8'h01;
      else if (np > 1000000 || np < -1000000) code = 8'h03;
      e = '{id: pend_id, price: 32'd0, volume: 32'd0, status: 8'h02, rv: 1'b1, rc: code,
            pu: 1'b0, psym: 32'd0, psize: 32'd0, ppnl: 32'd0};
      if (code == 8'h00) begin
         prod = pend_price * sh;
         pos_m[ix] = np;
         pnl_m[ix] = (pend_type == 8'h01) ? pnl_m[ix] - prod : pnl_m[ix] + prod;
         e.status = 8'h01;
         e.price  = pend_price;
         e.volume = pend_vol;
         e.pu     = 1'b1;
         e.psym   = pend_sym;
         e.psize  = 32'(np);
`ifdef ORDER_MANAGER_PNL_EN
         e.ppnl   = pnl_m[ix];
`endif
         rv_m = 1'b0;
         rc_m = 8'h00;
      end else begin
         rv_m = 1'b1;
         rc_m = code;
      end
      e.rv = rv_m;
      e.rc = rc_m;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] t, input logic [31:0] sym, input logic [31:0] pr,
                       input logic [31:0] vol, input logic [31:0] id);
      exp_t e;
      @(negedge clk);
      order_valid  = 1'b1;
      order_type   = t;
      order_symbol = sym;
      order_price  = pr;
      order_volume = vol;
      order_id     = id;
      if (t == 8'h03) begin
         e = '{id: id, price: 32'd0, volume: 32'd0, status: 8'h04, rv: 1'b0, rc: 8'h00,
               pu: 1'b0, psym: 32'd0, psize: 32'd0, ppnl: 32'd0};
         if (pend_v && (pend_type == 8'h01 || pend_type == 8'h02) && pend_id == id) begin
            pend_v = 1'b0;
            e.status = 8'h03;
         end else begin
            flush_pend();
         end
         e.rv = rv_m;
         e.rc = rc_m;
         exp_q.push_back(e);
      end else begin
         flush_pend();
         pend_v     = 1'b1;
         pend_type  = t;
         pend_sym   = sym;
         pend_price = pr;
         pend_vol   = vol;
         pend_id    = id;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         order_valid = 1'b0;
         flush_pend();
      end
   endtask

   task automatic check_outputs_zero(input string name);
      logic [31:0] got;
      got = {31'd0, order_ready} | {31'd0, execution_valid} | execution_id | execution_price
            | execution_volume | {24'd0, execution_status} | {31'd0, risk_violation}
            | {24'd0, risk_code} | {31'd0, position_update} | position_symbol | position_size
            | position_pnl;
      vectors++;
      if (got != 32'd0) begin
         miscompares++;
         $display("FAIL %s: OR of outputs got %h, required 00000000", name, got);
      end
   endtask

   // Monitor: compare every report against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && execution_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_report: got id=%h status=%h, required no report",
                        execution_id, execution_status);
            end else begin
               e = exp_q.pop_front();
               if (execution_id != e.id || execution_price != e.price
                   || execution_volume != e.volume || execution_status != e.status
                   || risk_violation != e.rv || risk_code != e.rc || position_update != e.pu
                   || (e.pu && (position_symbol != e.psym || position_size != e.psize
                                || position_pnl != e.ppnl))) begin
                  miscompares++;
                  $display({"FAIL report: got id=%h pr=%h vol=%h st=%h rv=%0d rc=%h pu=%0d ",
                            "sym=%h size=%h pnl=%h; required id=%h pr=%h vol=%h st=%h rv=%0d ",
                            "rc=%h pu=%0d sym=%h size=%h pnl=%h"},
                           execution_id, execution_price, execution_volume, execution_status,
                           risk_violation, risk_code, position_update, position_symbol,
                           position_size, position_pnl, e.id, e.price, e.volume, e.status,
                           e.rv, e.rc, e.pu, e.psym, e.psize, e.ppnl);
               end
            end
         end else if (rst_n && position_update) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_position_update: got 1, required 0");
         end
      end
   end

   initial begin
      model_clear();
      #12 check_outputs_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      vectors++;
      if (order_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL order_ready: got %b, required 1", order_ready);
      end

      // Back-to-back BUY then SELL on the same symbol
      send(8'h01, AAPL, 32'h96000000, 32'h64000000, 32'h12345678);
      send(8'h02, AAPL, 32'h95000000, 32'h32000000, 32'h87654321);
      idle(2);
      // Cancel hitting the order in S1, unknown-id cancel, cancel behind a different id
      send(8'h01, AAPL, 32'h96000000, 32'h64000000, 32'hABCDEF00);
      send(8'h03, AAPL, 32'h0, 32'h0, 32'hABCDEF00);
      idle(1);
      send(8'h03, AAPL, 32'h0, 32'h0, 32'hDEAD0001);
      send(8'h01, AAPL, 32'h10000000, 32'h01000000, 32'h00000200);
      send(8'h03, AAPL, 32'h0, 32'h0, 32'h00000999);
      idle(2);

      // Oversize volume reject, sticky for 10 cycles, then cleared by a fill
      send(8'h01, AAPL, 32'h96000000, 32'hFFFFFFFF, 32'h00000100);
      idle(10);
      vectors++;
      if (risk_violation !== 1'b1 || risk_code !== 8'h01) begin
         miscompares++;
         $display("FAIL risk_hold: got rv=%b rc=%h, required rv=1 rc=01", risk_violation,
                  risk_code);
      end
      send(8'h01, AAPL, 32'h96000000, 32'h01000000, 32'h00000101);
      idle(2);

      // Zero price / zero volume / illegal type (then a cancel of that id)
      send(8'h02, AAPL, 32'h00000000, 32'h01000000, 32'h00000102);
      send(8'h01, AAPL, 32'h01000000, 32'h00000000, 32'h00000103);
      send(8'h07, AAPL, 32'h01000000, 32'h01000000, 32'h00000300);
      send(8'h03, AAPL, 32'h0, 32'h0, 32'h00000300);
      // Volume boundary: exactly the limit fills, one above rejects
      send(8'h01, IBMX, 32'h02000000, 32'hF0000000, 32'h00000400);
      send(8'h01, IBMX, 32'h02000000, 32'hF0000001, 32'h00000401);
      idle(3);

      // Position limit: reach exactly 1000000, then one more share over
      for (int i = 0; i < 3921; i++) begin
         send(8'h01, MSFT, 32'h01000000, 32'hFF000000, 32'h10000 + i);
      end
      send(8'h01, MSFT, 32'h01000000, 32'h91000000, 32'h00020000);
      send(8'h01, MSFT, 32'h01000000, 32'h01000000, 32'h00020001);
      send(8'h02, MSFT, 32'h01000000, 32'h01000000, 32'h00020002);
      idle(3);

      // Reset mid-stream flushes in-flight orders and clears tables
      send(8'h01, AAPL, 32'h96000000, 32'h64000000, 32'h00000500);
      send(8'h02, AAPL, 32'h96000000, 32'h32000000, 32'h00000501);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      order_valid = 1'b0;
      model_clear();
      #1 check_outputs_zero("mid_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      send(8'h01, AAPL, 32'h96000000, 32'h64000000, 32'h00000600);
      idle(2);

      // Throughput: 100 BUYs with order_valid held high
      for (int i = 0; i < 100; i++) begin
         send(8'h01, GOOG, 32'h20000000, 32'h64000000, 32'h00001000 + i);
      end
      idle(4);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d reports outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
